// File: rtl/cache_refill_pkg.sv
// Shared cache geometry and refill-engine state encodings.
package cache_refill_pkg;

  localparam int unsigned CACHE_INDEX_AW  = 8;
  localparam int unsigned CACHE_OFFSET_AW = 4;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned CACHE_BANK_NUM  = 4;

  localparam int unsigned CACHE_REFILL_BEATS = CACHE_BANK_NUM;

  typedef enum logic [1:0] {
    CACHE_REFILL_IDLE = 2'd0,
    CACHE_REFILL_REQ  = 2'd1,
    CACHE_REFILL_FILL = 2'd2,
    CACHE_REFILL_DONE = 2'd3
  } cache_refill_state_e;

endpackage

// File: rtl/cache_refill.sv
// Line-refill engine: one aligned memory read, four beats written bank by bank into the
// data array, critical word forwarded, then a tag-write/done pulse.
module cache_refill
  import cache_refill_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned INDEX_AW  = CACHE_INDEX_AW,
  parameter int unsigned OFFSET_AW = CACHE_OFFSET_AW,
  parameter int unsigned DATA_W    = DATA_WIDTH,
  parameter int unsigned BEATS     = CACHE_REFILL_BEATS,
  parameter int unsigned TAG_W     = ADDR_W - INDEX_AW - OFFSET_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   miss_valid_i,
  output logic                   miss_ready_o,
  input  logic [ADDR_W-1:0]      miss_addr_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_W-1:0]      mem_req_addr_o,
  input  logic                   mem_rvalid_i,
  input  logic [DATA_W-1:0]      mem_rdata_i,
  input  logic                   mem_rlast_i,
  output logic [INDEX_AW-1:0]    data_index_o,
  output logic [OFFSET_AW-1:0]   data_offset_o,
  output logic [DATA_W/8-1:0]    data_wr_en_o,
  output logic [DATA_W-1:0]      data_wr_data_o,
  output logic                   crit_valid_o,
  output logic [DATA_W-1:0]      crit_data_o,
  output logic                   tag_wr_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   refill_done_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned BeatCw   = $clog2(BEATS);
  localparam int unsigned ByteOffW = OFFSET_AW - BeatCw;
  localparam logic [BeatCw-1:0] LastBeat = BeatCw'(BEATS - 1);

  cache_refill_state_e state_q, state_d;

  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_AW-1:0] index_q, index_d;
  logic [BeatCw-1:0]   crit_q, crit_d;
  logic [BeatCw-1:0]   beat_cnt_q, beat_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [BeatCw-1:0]   bank_q, bank_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                crit_valid_q, crit_valid_d;
  logic                err_q, err_d;
  logic                err_seen_q, err_seen_d;
  logic                last_mismatch;

  // Byte-within-word address bits never matter for a line refill.
  logic unused_addr;
  assign unused_addr = ^miss_addr_i[ByteOffW-1:0];

  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    index_d         = index_q;
    crit_d          = crit_q;
    beat_cnt_d      = beat_cnt_q;
    bank_d          = bank_q;
    wr_data_d       = wr_data_q;
    err_seen_d      = err_seen_q;
    wr_en_d         = 1'b0;
    crit_valid_d    = 1'b0;
    err_d           = 1'b0;
    last_mismatch   = 1'b0;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;

    case (state_q)
      CACHE_REFILL_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          tag_d   = miss_addr_i[ADDR_W-1 -: TAG_W];
          index_d = miss_addr_i[OFFSET_AW +: INDEX_AW];
          crit_d  = miss_addr_i[ByteOffW +: BeatCw];
          state_d = CACHE_REFILL_REQ;
        end
      end
      CACHE_REFILL_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          beat_cnt_d = '0;
          err_seen_d = 1'b0;
          state_d    = CACHE_REFILL_FILL;
        end
      end
      CACHE_REFILL_FILL: begin
        if (mem_rvalid_i) begin
          wr_en_d       = 1'b1;
          bank_d        = beat_cnt_q;
          wr_data_d     = mem_rdata_i;
          crit_valid_d  = (beat_cnt_q == crit_q);
          last_mismatch = mem_rlast_i != (beat_cnt_q == LastBeat);
          // Report only the first framing error of a refill; the count still rules.
          if (last_mismatch && !err_seen_q) begin
            err_d      = 1'b1;
            err_seen_d = 1'b1;
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LastBeat) begin
            state_d = CACHE_REFILL_DONE;
          end
        end
      end
      CACHE_REFILL_DONE: begin
        state_d = CACHE_REFILL_IDLE;
      end
      default: begin
        state_d = CACHE_REFILL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CACHE_REFILL_IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      crit_q       <= '0;
      beat_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      bank_q       <= '0;
      wr_data_q    <= '0;
      crit_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      crit_q       <= crit_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_en_q      <= wr_en_d;
      bank_q       <= bank_d;
      wr_data_q    <= wr_data_d;
      crit_valid_q <= crit_valid_d;
      err_q        <= err_d;
      err_seen_q   <= err_seen_d;
    end
  end

  assign mem_req_addr_o = {tag_q, index_q, {OFFSET_AW{1'b0}}};
  assign data_index_o   = index_q;
  assign data_offset_o  = {bank_q, {ByteOffW{1'b0}}};
  assign data_wr_en_o   = {(DATA_W/8){wr_en_q}};
  assign data_wr_data_o = wr_data_q;
  assign crit_valid_o   = crit_valid_q;
  assign crit_data_o    = wr_data_q;
  // The final bank write lands in the same cycle as DONE.
  assign tag_wr_o       = (state_q == CACHE_REFILL_DONE);
  assign refill_done_o  = (state_q == CACHE_REFILL_DONE);
  assign tag_o          = tag_q;
  assign busy_o         = (state_q != CACHE_REFILL_IDLE);
  assign err_o          = err_q;

endmodule

// File: doc/cache_refill.md
Name: cache_refill

Overview:
- Line-refill engine sitting directly upstream of the cache data array (4 x 32-bit banks per 128-bit line, 8-bit index, 4-bit offset).
- On a miss it issues one line-aligned read to memory and accepts 4 in-order 32-bit beats.
- It writes each beat into the data array one bank per cycle and forwards the critical (missed) word to the pipeline.
- It then pulses tag-write and done so the cache controller can retire the miss.

Parameters:
- ADDR_W, 32, physical address width
- INDEX_AW, 8, cache index width (addr[11:4])
- OFFSET_AW, 4, line offset width (addr[3:0])
- DATA_W, 32, beat and bank word width
- BEATS, 4, beats per line; must equal bank count
- TAG_W, ADDR_W-INDEX_AW-OFFSET_AW (20), tag width

Ports:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- miss_valid_i, in, 1, miss request valid
- miss_ready_o, out, 1, engine idle, can accept a miss
- miss_addr_i, in, ADDR_W, full missing address
- mem_req_valid_o, out, 1, memory read request valid
- mem_req_ready_i, in, 1, memory accepts request
- mem_req_addr_o, out, ADDR_W, line-aligned address (low OFFSET_AW bits zero)
- mem_rvalid_i, in, 1, read beat valid
- mem_rdata_i, in, DATA_W, read beat data
- mem_rlast_i, in, 1, memory marks final beat
- data_index_o, out, INDEX_AW, data-array index
- data_offset_o, out, OFFSET_AW, data-array offset; bits [3:2] select bank, [1:0] = 0
- data_wr_en_o, out, 4, byte enables; 4'hF on a write cycle, else 0
- data_wr_data_o, out, DATA_W, data-array write word
- crit_valid_o, out, 1, one-cycle pulse: critical word available
- crit_data_o, out, DATA_W, critical word
- tag_wr_o, out, 1, one-cycle pulse: write tag/valid for data_index_o
- tag_o, out, TAG_W, tag of the refilled line
- refill_done_o, out, 1, one-cycle pulse, same cycle as tag_wr_o
- busy_o, out, 1, state != IDLE
- err_o, out, 1, one-cycle pulse on rlast/beat-count mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE and beat_cnt=0.
- Reset values: all valid/pulse outputs 0, data_wr_en_o=0, address/data/tag registers 0, miss_ready_o=1 once out of reset.
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE:
  - miss_ready_o=1.
  - On miss_valid_i&miss_ready_o: latch tag, index and crit word = miss_addr_i[3:2]; go to REQ next cycle.
- REQ:
  - mem_req_valid_o=1; mem_req_addr_o={tag,index,4'b0}; both held stable until mem_req_ready_i.
  - On handshake go to FILL; beat_cnt=0.
- FILL:
  - Engine always accepts beats (no rdata backpressure).
  - Each cycle with mem_rvalid_i: capture the beat.
  - Next cycle the data-array write is registered: data_wr_en_o=4'hF, data_offset_o={beat_cnt_captured,2'b00}, data_index_o=latched index, data_wr_data_o=beat.
  - beat_cnt increments mod 4.
  - Gaps (rvalid=0) produce no write (wr_en=0).
- Critical word: when the captured beat number equals the latched crit word, crit_valid_o=1 with crit_data_o=beat, in the same cycle as that beat's data-array write.
- Beat count is authoritative:
  - The 4th beat ends FILL and moves to DONE.
  - If mem_rlast_i differs from (beat_cnt==3) on any beat, err_o pulses in the write cycle of that beat and the fill still proceeds by count.
- DONE:
  - Entered the cycle after the 4th beat is captured, so the last data-array write and DONE coincide.
  - tag_wr_o=1 and refill_done_o=1 for exactly one cycle; tag_o=latched tag.
  - Next state IDLE.
- Latency with zero-wait memory (miss accepted at cycle 0):
  - Cycle 1: request handshake.
  - Cycles 2-5: beats.
  - Cycles 3-6: writes.
  - Cycle 6: done.
- Simultaneous events:
  - A miss presented in DONE is not accepted (miss_ready_o=0); it is accepted in the following IDLE cycle.
  - mem_rvalid_i outside FILL is ignored.
- Reset mid-operation: FSM returns to IDLE immediately; no further writes or pulses; late memory beats arriving after reset are ignored.
- Output width: data_offset_o[1:0] is always 0.

Decomposition:
- INDEX_AW, OFFSET_AW, DATA_W, BEATS and the FSM state encodings go in the shared defines file (CACHE_INDEX_AW, CACHE_OFFSET_AW, DATA_WIDTH, CACHE_BANK_NUM already exist there).
- Add CACHE_REFILL_* state constants to the same file.
- No sub-module; the FSM, beat counter and output registers stay flat in one module.

Test Plan:
- Miss addr 0x1234_5678, zero-wait memory, beats 0xA0..0xA3:
  - Four writes at index 0x67, offsets 0x0/0x4/0x8/0xC, data A0..A3.
  - crit_valid_o with 0xA2 (word 2).
  - tag_o=0x12345 and done at cycle 6.
- mem_req_ready_i low 5 cycles: mem_req_valid_o and mem_req_addr_o=0x1234_5670 held stable; no writes until the handshake.
- Beats with gaps (rvalid pattern 1,0,0,1,1,0,1): exactly 4 writes, no write on gap cycles; done the cycle after the 4th capture.
- mem_rlast_i on beat 2 instead of 3: err_o pulses once, still 4 writes, done as normal.
- Back-to-back misses, second miss_valid_i held through the first refill: second accepted in the first IDLE after DONE; correct index/tag for both.
- rst_n asserted during FILL after 2 beats: all outputs 0 immediately, remaining beats produce no write, next miss refills correctly.
